// File: rtl/sandbox_host_link.sv
`default_nettype none
// ============================================================================
// Module      : sandbox_host_link
// Description : Host-side framer/deframer between the UART byte layer and the
//               sandbox process. Collects 5-byte command frames into
//               control/inputData and serializes status/outputData into a
//               5-byte response frame on a transmitData rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module sandbox_host_link #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TO_WIDTH       = 17
) (
    input  logic        masterClock,
    input  logic        reset,
    input  logic        rxByteValid,
    input  logic [7:0]  rxByte,
    output logic        rxByteReady,
    output logic        txByteValid,
    output logic [7:0]  txByte,
    input  logic        txByteReady,
    output logic        dataReceived,
    output logic [7:0]  control,
    output logic [31:0] inputData,
    input  logic        clearDR,
    input  logic        transmitData,
    input  logic [7:0]  status,
    input  logic [31:0] outputData,
    output logic        rxFrameError,
    output logic        txOverrun
);

    typedef enum logic [1:0] {
        R_IDLE    = 2'd0,
        R_COLLECT = 2'd1,
        R_FULL    = 2'd2
    } rxState_t;

    typedef enum logic [0:0] {
        T_IDLE = 1'b0,
        T_SEND = 1'b1
    } txState_t;

    // A zero timeout disables the inter-byte watchdog; the timer then counts harmlessly.
    localparam logic                c_TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_WIDTH-1:0] c_TIMEOUT_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Receive side
    // ------------------------------------------------------------------
    rxState_t            r_rxState;
    rxState_t            w_rxNext;
    logic [2:0]          r_rxIndex;
    logic [39:0]         r_rxFrame;
    logic [TO_WIDTH-1:0] r_rxTimer;
    logic                r_dataReceived;
    logic [7:0]          r_control;
    logic [31:0]         r_inputData;
    logic                r_rxFrameError;

    logic                w_rxAccept;
    logic                w_slotFree;
    logic                w_loadDirect;
    logic                w_loadHeld;
    logic                w_timeout;
    logic [39:0]         w_rxAssembled;

    // Bytes shift in from the top so that after five bytes byte0 sits in [7:0].
    assign w_rxAssembled = {rxByte, r_rxFrame[39:8]};
    assign rxByteReady   = reset && (r_rxState != R_FULL);
    assign w_rxAccept    = rxByteValid && rxByteReady;
    assign w_slotFree    = !r_dataReceived && !clearDR;

    // RX state register.
    always_ff @(posedge masterClock) begin
        if (!reset) begin
            r_rxState <= R_IDLE;
        end else begin
            r_rxState <= w_rxNext;
        end
    end

    // RX next-state: frame completion, slot handoff and inter-byte timeout.
    always_comb begin
        w_rxNext     = r_rxState;
        w_loadDirect = 1'b0;
        w_loadHeld   = 1'b0;
        w_timeout    = 1'b0;
        case (r_rxState)
            R_IDLE: begin
                if (w_rxAccept) begin
                    w_rxNext = R_COLLECT;
                end
            end
            R_COLLECT: begin
                if (w_rxAccept) begin
                    if (r_rxIndex == 3'd4) begin
                        if (w_slotFree) begin
                            w_loadDirect = 1'b1;
                            w_rxNext     = R_IDLE;
                        end else begin
                            w_rxNext = R_FULL;
                        end
                    end
                end else if (c_TIMEOUT_EN && (r_rxTimer == c_TIMEOUT_LAST)) begin
                    w_timeout = 1'b1;
                    w_rxNext  = R_IDLE;
                end
            end
            R_FULL: begin
                if (w_slotFree) begin
                    w_loadHeld = 1'b1;
                    w_rxNext   = R_IDLE;
                end
            end
            default: begin
                w_rxNext = R_IDLE;
            end
        endcase
    end

    // RX datapath: byte shifting, byte index and the inter-byte timer.
    always_ff @(posedge masterClock) begin
        if (!reset) begin
            r_rxIndex      <= 3'd0;
            r_rxFrame      <= 40'd0;
            r_rxTimer      <= '0;
            r_rxFrameError <= 1'b0;
        end else begin
            r_rxFrameError <= w_timeout;
            if (w_rxAccept) begin
                r_rxFrame <= w_rxAssembled;
                r_rxIndex <= (r_rxIndex == 3'd4) ? 3'd0 : r_rxIndex + 3'd1;
                r_rxTimer <= '0;
            end else if (r_rxState == R_COLLECT) begin
                if (w_timeout) begin
                    r_rxIndex <= 3'd0;
                    r_rxTimer <= '0;
                end else begin
                    r_rxTimer <= r_rxTimer + TO_WIDTH'(1);
                end
            end
        end
    end

    // Handoff slot: load a finished frame, retire it on clearDR.
    always_ff @(posedge masterClock) begin
        if (!reset) begin
            r_dataReceived <= 1'b0;
            r_control      <= 8'd0;
            r_inputData    <= 32'd0;
        end else if (w_loadDirect) begin
            r_dataReceived <= 1'b1;
            r_control      <= w_rxAssembled[7:0];
            r_inputData    <= w_rxAssembled[39:8];
        end else if (w_loadHeld) begin
            r_dataReceived <= 1'b1;
            r_control      <= r_rxFrame[7:0];
            r_inputData    <= r_rxFrame[39:8];
        end else if (clearDR) begin
            r_dataReceived <= 1'b0;
        end
    end

    assign dataReceived = r_dataReceived;
    assign control      = r_control;
    assign inputData    = r_inputData;
    assign rxFrameError = r_rxFrameError;

    // ------------------------------------------------------------------
    // Transmit side
    // ------------------------------------------------------------------
    txState_t    r_txState;
    txState_t    w_txNext;
    logic        r_txPrev;
    logic [39:0] r_txShift;
    logic [2:0]  r_txIndex;
    logic        r_txOverrun;

    logic        w_txRise;
    logic        w_txHandshake;
    logic        w_txCapture;

    assign w_txRise      = transmitData && !r_txPrev;
    assign w_txHandshake = (r_txState == T_SEND) && txByteReady;

    // TX state register.
    always_ff @(posedge masterClock) begin
        if (!reset) begin
            r_txState <= T_IDLE;
        end else begin
            r_txState <= w_txNext;
        end
    end

    // TX next-state: start on a rise when idle, finish after the fifth handshake.
    always_comb begin
        w_txNext    = r_txState;
        w_txCapture = 1'b0;
        case (r_txState)
            T_IDLE: begin
                if (w_txRise) begin
                    w_txCapture = 1'b1;
                    w_txNext    = T_SEND;
                end
            end
            T_SEND: begin
                if (w_txHandshake && (r_txIndex == 3'd4)) begin
                    w_txNext = T_IDLE;
                end
            end
            default: begin
                w_txNext = T_IDLE;
            end
        endcase
    end

    // TX datapath: edge tracking, response shift register and overrun flag.
    // The edge tracker keeps following transmitData during reset so a level held
    // high across reset does not look like a fresh request afterwards.
    always_ff @(posedge masterClock) begin
        r_txPrev <= transmitData;
        if (!reset) begin
            r_txShift   <= 40'd0;
            r_txIndex   <= 3'd0;
            r_txOverrun <= 1'b0;
        end else begin
            if (w_txCapture) begin
                r_txShift <= {outputData, status};
                r_txIndex <= 3'd0;
            end else if (w_txHandshake) begin
                if (r_txIndex == 3'd4) begin
                    r_txIndex <= 3'd0;
                end else begin
                    r_txShift <= {8'h00, r_txShift[39:8]};
                    r_txIndex <= r_txIndex + 3'd1;
                end
            end
            if ((r_txState == T_SEND) && w_txRise) begin
                r_txOverrun <= 1'b1;
            end
        end
    end

    assign txByteValid = (r_txState == T_SEND);
    assign txByte      = r_txShift[7:0];
    assign txOverrun   = r_txOverrun;

endmodule
`default_nettype wire

// File: tb/tb_sandbox_host_link.sv
`default_nettype none
// ============================================================================
// Module      : tb_sandbox_host_link
// Description : Self-checking bench for sandbox_host_link. Random command and
//               response frames are compared against expectations derived
//               from the frame format (byte0 = control/status, then data
//               little-endian byte order).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sandbox_host_link;

    logic        masterClock = 1'b0;
    logic        reset       = 1'b0;
    logic        rxByteValid = 1'b0;
    logic [7:0]  rxByte      = 8'h00;
    logic        rxByteReady;
    logic        txByteValid;
    logic [7:0]  txByte;
    logic        txByteReady = 1'b0;
    logic        dataReceived;
    logic [7:0]  control;
    logic [31:0] inputData;
    logic        clearDR     = 1'b0;
    logic        transmitData = 1'b0;
    logic [7:0]  status      = 8'h00;
    logic [31:0] outputData  = 32'h0;
    logic        rxFrameError;
    logic        txOverrun;

    int checks   = 0;
    int failures = 0;
    logic [7:0] txGot[$];

    sandbox_host_link #(
        .TIMEOUT_CYCLES(16),
        .TO_WIDTH      (17)
    ) dut (
        .masterClock (masterClock),
        .reset       (reset),
        .rxByteValid (rxByteValid),
        .rxByte      (rxByte),
        .rxByteReady (rxByteReady),
        .txByteValid (txByteValid),
        .txByte      (txByte),
        .txByteReady (txByteReady),
        .dataReceived(dataReceived),
        .control     (control),
        .inputData   (inputData),
        .clearDR     (clearDR),
        .transmitData(transmitData),
        .status      (status),
        .outputData  (outputData),
        .rxFrameError(rxFrameError),
        .txOverrun   (txOverrun)
    );

    always #5 masterClock = ~masterClock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge masterClock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one byte after an optional idle gap; waits (bounded) for readiness.
    task automatic sendByte(input logic [7:0] b, input int gap);
        int w;
        rxByteValid = 1'b0;
        repeat (gap) tick;
        rxByteValid = 1'b1;
        rxByte      = b;
        w = 0;
        while (!rxByteReady && w < 50) begin
            tick;
            w++;
        end
        check("rx_ready_before_accept", rxByteReady, 1);
        tick;
        rxByteValid = 1'b0;
    endtask

    // Frame on the wire: ctrl first, then data least-significant byte first.
    task automatic sendFrame(input logic [7:0] ctrl, input logic [31:0] data, input int maxGap);
        sendByte(ctrl, $urandom_range(0, maxGap));
        for (int i = 0; i < 4; i++) begin
            sendByte(8'((data >> (8 * i)) & 32'hFF), $urandom_range(0, maxGap));
        end
    endtask

    task automatic expectSlot(input string tag, input logic [7:0] ctrl, input logic [31:0] data);
        check({tag, "_dr"},   dataReceived, 1);
        check({tag, "_ctrl"}, control, ctrl);
        check({tag, "_data"}, inputData, data);
    endtask

    task automatic retireSlot(input int holdCycles);
        clearDR = 1'b1;
        repeat (holdCycles) tick;
        check("slot_cleared", dataReceived, 0);
        clearDR = 1'b0;
        tick;
    endtask

    // Raise transmitData from a known low level and confirm byte0 is presented.
    task automatic startTx(input logic [7:0] st, input logic [31:0] od);
        txByteReady  = 1'b0;
        transmitData = 1'b0;
        tick;
        status       = st;
        outputData   = od;
        transmitData = 1'b1;
        tick;
        check("tx_valid_after_rise", txByteValid, 1);
        check("tx_first_byte", txByte, st);
    endtask

    // Drain the response with a random ready pattern, checking stall stability.
    task automatic collectTx(input int budget);
        logic       stall;
        logic [7:0] held;
        txGot.delete();
        for (int c = 0; c < budget; c++) begin
            txByteReady = 1'($urandom_range(0, 1));
            stall = txByteValid && !txByteReady;
            held  = txByte;
            if (txByteValid && txByteReady) txGot.push_back(txByte);
            tick;
            if (stall) begin
                check("tx_stall_valid", txByteValid, 1);
                check("tx_stall_byte", txByte, held);
            end
        end
        txByteReady = 1'b0;
    endtask

    task automatic verifyTx(input logic [7:0] st, input logic [31:0] od);
        logic [31:0] expB;
        logic [31:0] gotB;
        check("tx_byte_count", txGot.size(), 5);
        for (int i = 0; i < 5; i++) begin
            expB = (i == 0) ? {24'h0, st} : ((od >> (8 * (i - 1))) & 32'hFF);
            gotB = (i < txGot.size()) ? {24'h0, txGot[i]} : 32'hFFFF_FFFF;
            check($sformatf("tx_byte%0d", i), gotB, expB);
        end
    endtask

    initial begin
        logic [7:0]  ctrlA, ctrlB, st;
        logic [31:0] dataA, dataB, od;
        int          pulses, firstAt, validCycles;

        // Reset state
        reset = 1'b0;
        repeat (3) tick;
        check("rst_rxReady", rxByteReady, 0);
        check("rst_txValid", txByteValid, 0);
        check("rst_txByte", txByte, 0);
        check("rst_dr", dataReceived, 0);
        check("rst_ctrl", control, 0);
        check("rst_data", inputData, 0);
        check("rst_frameErr", rxFrameError, 0);
        check("rst_overrun", txOverrun, 0);
        reset = 1'b1;
        tick;
        check("rxReady_after_reset", rxByteReady, 1);

        // 1: fixed back-to-back frame
        sendFrame(8'h05, 32'h11223344, 0);
        expectSlot("frame1", 8'h05, 32'h11223344);
        retireSlot(1);

        // Random frames with random gaps and clear lengths
        for (int k = 0; k < 4; k++) begin
            ctrlA = 8'($urandom);
            dataA = $urandom;
            sendFrame(ctrlA, dataA, 3);
            expectSlot("rand_frame", ctrlA, dataA);
            retireSlot($urandom_range(1, 3));
        end

        // 2: second frame while slot occupied -> back-pressure, then handoff
        ctrlA = 8'($urandom);  dataA = $urandom;
        ctrlB = 8'($urandom);  dataB = $urandom;
        sendFrame(ctrlA, dataA, 0);
        expectSlot("slotA", ctrlA, dataA);
        sendFrame(ctrlB, dataB, 1);
        check("full_rxReady", rxByteReady, 0);
        expectSlot("slotA_held", ctrlA, dataA);
        repeat (3) tick;
        check("full_rxReady_hold", rxByteReady, 0);
        clearDR = 1'b1;
        tick;
        check("full_clear_dr", dataReceived, 0);
        check("full_clear_ctrl_holds", control, ctrlA);
        clearDR = 1'b0;
        tick;
        expectSlot("slotB", ctrlB, dataB);
        check("full_rxReady_back", rxByteReady, 1);
        retireSlot(1);

        // 3: response frame with stalls
        startTx(8'h01, 32'hAABBCCDD);
        collectTx(80);
        verifyTx(8'h01, 32'hAABBCCDD);
        check("tx_idle_after_frame", txByteValid, 0);
        for (int k = 0; k < 2; k++) begin
            st = 8'($urandom);
            od = $urandom;
            startTx(st, od);
            collectTx(80);
            verifyTx(st, od);
        end

        // 4: inter-byte timeout after two bytes
        sendByte(8'($urandom), 0);
        sendByte(8'($urandom), 0);
        pulses  = 0;
        firstAt = 0;
        for (int i = 1; i <= 30; i++) begin
            tick;
            if (rxFrameError) begin
                pulses++;
                if (firstAt == 0) firstAt = i;
            end
        end
        check("timeout_pulse_count", pulses, 1);
        check("timeout_cycle", firstAt, 16);
        check("timeout_no_load", dataReceived, 0);
        ctrlA = 8'($urandom);  dataA = $urandom;
        sendFrame(ctrlA, dataA, 2);
        expectSlot("after_timeout", ctrlA, dataA);
        retireSlot(1);

        // 5: second rise during transmission
        st = 8'($urandom);
        od = $urandom;
        startTx(st, od);
        transmitData = 1'b0;
        tick;
        status       = ~st;
        outputData   = ~od;
        transmitData = 1'b1;
        tick;
        check("overrun_set", txOverrun, 1);
        collectTx(80);
        verifyTx(st, od);
        txByteReady = 1'b1;
        validCycles = 0;
        repeat (10) begin
            tick;
            if (txByteValid) validCycles++;
        end
        txByteReady = 1'b0;
        check("overrun_no_extra_bytes", validCycles, 0);
        check("overrun_sticky", txOverrun, 1);
        reset = 1'b0;
        tick;
        check("overrun_cleared_by_reset", txOverrun, 0);
        reset = 1'b1;
        tick;

        // 6: reset mid RX frame and mid TX frame
        sendByte(8'($urandom), 0);
        sendByte(8'($urandom), 0);
        sendByte(8'($urandom), 0);
        st = 8'($urandom);
        od = $urandom;
        startTx(st, od);
        txByteReady = 1'b1;
        tick;
        txByteReady = 1'b0;
        check("tx_second_byte_inflight", txByte, od & 32'hFF);
        reset = 1'b0;
        tick;
        check("mid_rst_rxReady", rxByteReady, 0);
        check("mid_rst_txValid", txByteValid, 0);
        check("mid_rst_txByte", txByte, 0);
        check("mid_rst_dr", dataReceived, 0);
        check("mid_rst_ctrl", control, 0);
        check("mid_rst_data", inputData, 0);
        check("mid_rst_frameErr", rxFrameError, 0);
        check("mid_rst_overrun", txOverrun, 0);
        reset = 1'b1;
        txByteReady = 1'b1;
        validCycles = 0;
        repeat (6) begin
            tick;
            if (txByteValid) validCycles++;
        end
        txByteReady = 1'b0;
        check("post_rst_no_tx", validCycles, 0);
        ctrlA = 8'($urandom);  dataA = $urandom;
        sendFrame(ctrlA, dataA, 1);
        expectSlot("post_rst_frame", ctrlA, dataA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
